// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
//
// Captures decoded control and datapath fields from ID once per enabled clock
// edge. When the load currently in EX writes a register that the instruction
// in ID reads, the stage inserts a one-cycle bubble and asks upstream to hold
// (stall_o). A branch flush also inserts a bubble, and it takes priority over
// the stall, so a squashed instruction never causes a stall.
//
// Ports
//   clk_i, rst_i     rising-edge clock, asynchronous active-low reset
//   en_i             global advance enable (0 = every register holds)
//   flush_i          squash the instruction currently in ID
//   *_i              decoder control / datapath fields for the ID instruction
//   *_o              registered copies for EX (one cycle latency)
//   stall_o          combinational: hold PC and IF/ID this cycle
//   stall_cnt_o      saturating count of load-use stall cycles
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        flush_i,
  input  logic [1:0]  ALUOp_i,
  input  logic        ALUSrc_i,
  input  logic [1:0]  Mem_i,
  input  logic        WB_i,
  input  logic [31:0] RS1data_i,
  input  logic [31:0] RS2data_i,
  input  logic [31:0] imm_i,
  input  logic [9:0]  funct_i,
  input  logic [4:0]  RS1addr_i,
  input  logic [4:0]  RS2addr_i,
  input  logic [4:0]  RDaddr_i,
  output logic [1:0]  ALUOp_o,
  output logic        ALUSrc_o,
  output logic [1:0]  Mem_o,
  output logic        WB_o,
  output logic [31:0] RS1data_o,
  output logic [31:0] RS2data_o,
  output logic [31:0] imm_o,
  output logic [9:0]  funct_o,
  output logic [4:0]  RS1addr_o,
  output logic [4:0]  RS2addr_o,
  output logic [4:0]  RDaddr_o,
  output logic        stall_o,
  output logic [15:0] stall_cnt_o
);

  localparam logic [1:0]  MEM_RD  = 2'b01;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic hazard;
  logic bubble;

  // Load in EX whose destination is a source of the ID instruction. x0 is
  // never a real dependency, and stores (Mem_o=10) never produce data.
  assign hazard = (Mem_o == MEM_RD) && (RDaddr_o != 5'd0) &&
                  ((RDaddr_o == RS1addr_i) || (RDaddr_o == RS2addr_i));

  // A flushed instruction is discarded anyway, so no stall is needed.
  assign stall_o = hazard & ~flush_i & en_i;
  assign bubble  = en_i & (flush_i | hazard);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ALUOp_o     <= '0;
      ALUSrc_o    <= 1'b0;
      Mem_o       <= '0;
      WB_o        <= 1'b0;
      RS1data_o   <= '0;
      RS2data_o   <= '0;
      imm_o       <= '0;
      funct_o     <= '0;
      RS1addr_o   <= '0;
      RS2addr_o   <= '0;
      RDaddr_o    <= '0;
      stall_cnt_o <= '0;
    end else if (en_i) begin
      // Bubble kills every side effect; RDaddr_o is cleared too so the bubble
      // cannot match the re-presented instruction next cycle, which bounds a
      // load-use stall to one cycle.
      ALUOp_o   <= bubble ? 2'b00 : ALUOp_i;
      ALUSrc_o  <= bubble ? 1'b0  : ALUSrc_i;
      Mem_o     <= bubble ? 2'b00 : Mem_i;
      WB_o      <= bubble ? 1'b0  : WB_i;
      RDaddr_o  <= bubble ? 5'd0  : RDaddr_i;
      // Remaining datapath fields are don't-care in a bubble; loading them
      // unconditionally keeps the behaviour deterministic and the mux count low.
      RS1data_o <= RS1data_i;
      RS2data_o <= RS2data_i;
      imm_o     <= imm_i;
      funct_o   <= funct_i;
      RS1addr_o <= RS1addr_i;
      RS2addr_o <= RS2addr_i;
      if (stall_o && (stall_cnt_o != CNT_MAX))
        stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, en_i, flush_i;
  logic [1:0]  ALUOp_i, Mem_i;
  logic        ALUSrc_i, WB_i;
  logic [31:0] RS1data_i, RS2data_i, imm_i;
  logic [9:0]  funct_i;
  logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;
  logic [1:0]  ALUOp_o, Mem_o;
  logic        ALUSrc_o, WB_o;
  logic [31:0] RS1data_o, RS2data_o, imm_o;
  logic [9:0]  funct_o;
  logic [4:0]  RS1addr_o, RS2addr_o, RDaddr_o;
  logic        stall_o;
  logic [15:0] stall_cnt_o;

  int err_cnt = 0;
  int chk_cnt = 0;
  int exp_cnt;

  always #5 clk_i = ~clk_i;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .flush_i(flush_i),
    .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .Mem_i(Mem_i), .WB_i(WB_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .imm_i(imm_i), .funct_i(funct_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .Mem_o(Mem_o), .WB_o(WB_o),
    .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .imm_o(imm_o), .funct_o(funct_o),
    .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] aluop, input logic alusrc, input logic [1:0] mem,
                       input logic wb, input logic [31:0] rs1d, input logic [31:0] rs2d,
                       input logic [31:0] imm, input logic [9:0] funct,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    ALUOp_i = aluop; ALUSrc_i = alusrc; Mem_i = mem; WB_i = wb;
    RS1data_i = rs1d; RS2data_i = rs2d; imm_i = imm; funct_i = funct;
    RS1addr_i = rs1; RS2addr_i = rs2; RDaddr_i = rd;
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b1; flush_i = 1'b0;
    drive(2'd0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 10'd0, 5'd0, 5'd0, 5'd0);

    // ---- reset ----
    #2 rst_i = 1'b0;
    #1;
    chk("rst_mem", Mem_o, 0);
    chk("rst_wb", WB_o, 0);
    chk("rst_rd", RDaddr_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    chk("rst_stall", stall_o, 0);
    cyc;
    chk("rst_hold_mem", Mem_o, 0);
    #7 rst_i = 1'b1;
    cyc;

    // ---- load-use: ld x5 then add x6,x5,x7 ----
    drive(2'd0, 1'b1, 2'b01, 1'b1, 32'h1000, 32'h0, 32'd8, 10'h002, 5'd2, 5'd0, 5'd5);
    #1 chk("lu_pre_stall", stall_o, 0);
    cyc;
    chk("lu_ld_mem", Mem_o, 1);
    chk("lu_ld_rd", RDaddr_o, 5);
    chk("lu_ld_wb", WB_o, 1);
    chk("lu_ld_imm", imm_o, 8);
    chk("lu_ld_alusrc", ALUSrc_o, 1);
    chk("lu_ld_funct", funct_o, 10'h002);
    chk("lu_ld_rs1d", RS1data_o, 32'h1000);
    chk("lu_ld_rs1a", RS1addr_o, 2);
    drive(2'd2, 1'b0, 2'b00, 1'b1, 32'd111, 32'd222, 32'd0, 10'h000, 5'd5, 5'd7, 5'd6);
    #1 chk("lu_stall", stall_o, 1);
    cyc;
    chk("lu_bub_wb", WB_o, 0);
    chk("lu_bub_mem", Mem_o, 0);
    chk("lu_bub_rd", RDaddr_o, 0);
    chk("lu_bub_aluop", ALUOp_o, 0);
    chk("lu_bub_rs1d", RS1data_o, 111);
    chk("lu_bub_rs2a", RS2addr_o, 7);
    chk("lu_cnt", stall_cnt_o, 1);
    chk("lu_stall_clr", stall_o, 0);
    cyc;
    chk("lu_add_aluop", ALUOp_o, 2);
    chk("lu_add_rd", RDaddr_o, 6);
    chk("lu_add_wb", WB_o, 1);
    chk("lu_add_rs2d", RS2data_o, 222);
    chk("lu_add_cnt", stall_cnt_o, 1);

    // ---- load to x0, then a store: neither stalls ----
    drive(2'd0, 1'b1, 2'b01, 1'b1, 32'd0, 32'd0, 32'd4, 10'h002, 5'd3, 5'd0, 5'd0);
    cyc;
    chk("x0_mem", Mem_o, 1);
    drive(2'd2, 1'b0, 2'b00, 1'b1, 32'd0, 32'd0, 32'd0, 10'h000, 5'd0, 5'd0, 5'd8);
    #1 chk("x0_stall", stall_o, 0);
    cyc;
    chk("x0_next_rd", RDaddr_o, 8);
    drive(2'd0, 1'b1, 2'b10, 1'b0, 32'd0, 32'd0, 32'd12, 10'h002, 5'd2, 5'd4, 5'd5);
    cyc;
    chk("st_mem", Mem_o, 2);
    chk("st_rd", RDaddr_o, 5);
    drive(2'd2, 1'b0, 2'b00, 1'b1, 32'd0, 32'd0, 32'd0, 10'h000, 5'd1, 5'd5, 5'd9);
    #1 chk("st_stall", stall_o, 0);
    cyc;
    chk("st_next_rd", RDaddr_o, 9);
    chk("st_cnt", stall_cnt_o, 1);

    // ---- flush wins over a simultaneous hazard ----
    drive(2'd0, 1'b1, 2'b01, 1'b1, 32'd0, 32'd0, 32'd0, 10'h002, 5'd1, 5'd0, 5'd9);
    cyc;
    chk("fl_ld_mem", Mem_o, 1);
    drive(2'd2, 1'b0, 2'b00, 1'b1, 32'd0, 32'd0, 32'd0, 10'h000, 5'd9, 5'd0, 5'd12);
    flush_i = 1'b1;
    #1 chk("fl_stall", stall_o, 0);
    cyc;
    flush_i = 1'b0;
    chk("fl_bub_wb", WB_o, 0);
    chk("fl_bub_rd", RDaddr_o, 0);
    chk("fl_bub_aluop", ALUOp_o, 0);
    chk("fl_cnt", stall_cnt_o, 1);

    // ---- freeze with en_i=0 and a pending hazard ----
    drive(2'd0, 1'b1, 2'b01, 1'b1, 32'hABCD, 32'd0, 32'd16, 10'h002, 5'd1, 5'd0, 5'd10);
    cyc;
    en_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(2'(k + 1), 1'b0, 2'(k), 1'(k), 32'(k * 7 + 1), 32'(k), 32'(k * 3 + 100),
            10'(k + 5), 5'd10, 5'(k), 5'(20 + k));
      #1 chk("fz_stall", stall_o, 0);
      cyc;
      chk("fz_mem", Mem_o, 1);
      chk("fz_rd", RDaddr_o, 10);
      chk("fz_imm", imm_o, 16);
      chk("fz_wb", WB_o, 1);
      chk("fz_rs1d", RS1data_o, 32'hABCD);
      chk("fz_cnt", stall_cnt_o, 1);
    end
    en_i = 1'b1;
    drive(2'd2, 1'b0, 2'b00, 1'b1, 32'd0, 32'd0, 32'd0, 10'h000, 5'd10, 5'd0, 5'd11);
    #1 chk("fz_rel_stall", stall_o, 1);
    cyc;
    chk("fz_rel_rd", RDaddr_o, 0);
    chk("fz_rel_cnt", stall_cnt_o, 2);

    // ---- back-to-back loads through RS2: stall every other cycle ----
    exp_cnt = 2;
    drive(2'd0, 1'b1, 2'b01, 1'b1, 32'd0, 32'd0, 32'd4, 10'h002, 5'd0, 5'd5, 5'd5);
    #1;
    for (int i = 0; i < 40; i++) begin
      chk("rep_stall", stall_o, 32'(i % 2));
      if (i % 2 == 1) exp_cnt++;
      cyc;
      chk("rep_cnt", stall_cnt_o, 32'(exp_cnt));
    end

    // ---- saturation: preload near max, then two more stalls ----
    en_i = 1'b0;
    force dut.stall_cnt_o = 16'hFFFE;
    #1 release dut.stall_cnt_o;
    #1 chk("sat_preload", stall_cnt_o, 16'hFFFE);
    en_i = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("sat_stall", stall_o, 32'(i % 2));
      cyc;
      chk("sat_cnt", stall_cnt_o, (i >= 1) ? 32'hFFFF : 32'hFFFE);
    end

    // ---- asynchronous reset while a load-use stall is pending ----
    cyc;
    chk("ar_mem_pre", Mem_o, 1);
    #1 chk("ar_stall_pre", stall_o, 1);
    #1 rst_i = 1'b0;
    #1;
    chk("ar_mem", Mem_o, 0);
    chk("ar_wb", WB_o, 0);
    chk("ar_rd", RDaddr_o, 0);
    chk("ar_imm", imm_o, 0);
    chk("ar_rs2a", RS2addr_o, 0);
    chk("ar_cnt", stall_cnt_o, 0);
    chk("ar_stall", stall_o, 0);
    cyc;
    chk("ar_hold_mem", Mem_o, 0);
    #2 rst_i = 1'b1;
    cyc;
    chk("ar_post_mem", Mem_o, 1);
    chk("ar_post_rd", RDaddr_o, 5);
    chk("ar_post_wb", WB_o, 1);
    chk("ar_post_cnt", stall_cnt_o, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
